// File: rtl/alu_operand_b_sel.sv
// ALU operand-B source select with immediate extension, registered behind a
// valid/ready handshake with a one-entry skid buffer and illegal-select counting.
module alu_operand_b_sel #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 4,
    parameter int SEL_W     = 3,
    parameter int IMM_W     = 16,
    parameter int CONST_VAL = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [1:0]               ext_mode,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [IMM_W-1:0]         imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         operand,
    output logic                     sel_err,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam logic [SEL_W-1:0] SEL_CONST = SEL_W'(NUM_SRC);
    localparam logic [SEL_W-1:0] SEL_IMM   = SEL_W'(NUM_SRC + 1);
    localparam int               PAD_W     = WIDTH - IMM_W;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_SHL2  = 2'b10;
    localparam logic [1:0] EXT_UPPER = 2'b11;

    logic [WIDTH-1:0]     w_imm_sext;
    logic [WIDTH-1:0]     w_imm_zext;
    logic [WIDTH-1:0]     w_imm_shl2;
    logic [WIDTH-1:0]     w_imm_upper;
    logic [WIDTH-1:0]     w_imm_ext;
    logic [WIDTH-1:0]     w_sel_data;
    logic                 w_sel_err;
    logic                 w_accept;
    logic                 w_out_free;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_err;
    logic                 r_skid_valid;
    logic [WIDTH-1:0]     r_skid_data;
    logic                 r_skid_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    assign w_imm_sext  = {{PAD_W{imm[IMM_W-1]}}, imm};
    assign w_imm_zext  = {{PAD_W{1'b0}}, imm};
    assign w_imm_shl2  = {w_imm_sext[WIDTH-3:0], 2'b00};
    assign w_imm_upper = {imm, {PAD_W{1'b0}}};

    always_comb begin
        w_imm_ext = w_imm_sext;
        case (ext_mode)
            EXT_SIGN:  w_imm_ext = w_imm_sext;
            EXT_ZERO:  w_imm_ext = w_imm_zext;
            EXT_SHL2:  w_imm_ext = w_imm_shl2;
            EXT_UPPER: w_imm_ext = w_imm_upper;
            default:   w_imm_ext = w_imm_sext;
        endcase
    end

    // Anything beyond the sources, the constant and the immediate is illegal.
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = src_flat[k*WIDTH +: WIDTH];
                w_sel_err  = 1'b0;
            end
        end
        if (sel == SEL_CONST) begin
            w_sel_data = WIDTH'(CONST_VAL);
            w_sel_err  = 1'b0;
        end
        if (sel == SEL_IMM) begin
            w_sel_data = w_imm_ext;
            w_sel_err  = 1'b0;
        end
    end

    assign in_ready   = !r_skid_valid && !reset;
    assign w_accept   = in_valid && in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // The skid only fills while the output is stalled, so a full skid always
    // implies a valid output and in_ready low; drain and accept never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_err   <= w_sel_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_sel_data;
            r_skid_err   <= w_sel_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_sel_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign operand   = r_out_data;
    assign sel_err   = r_out_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_operand_b_sel.sv
// Directed and randomized checks of alu_operand_b_sel against a queue-based
// transaction model.
module tb_alu_operand_b_sel;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   sel;
    logic [1:0]   ext_mode;
    logic [127:0] src_flat;
    logic [15:0]  imm;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  operand;
    logic         sel_err;
    logic [7:0]   err_count;

    logic [31:0]  src [4];

    typedef struct {
        logic [31:0] d;
        logic        e;
    } ent_t;

    ent_t q[$];
    int   errc;
    int   n_cmp;
    int   n_bad;

    assign src_flat = {src[3], src[2], src[1], src[0]};

    alu_operand_b_sel dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .ext_mode  (ext_mode),
        .src_flat  (src_flat),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand   (operand),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected operand from the decode rules, computed arithmetically.
    function automatic ent_t ref_op(input int s, input int m, input int im);
        ent_t   r;
        longint v;
        longint mask;
        mask = 64'h0000_0000_FFFF_FFFF;
        v = im;
        if (v >= 32768) v = v - 65536;
        r.e = 1'b0;
        if (s < 4) r.d = src[s];
        else if (s == 4) r.d = 32'd4;
        else if (s == 5) begin
            case (m)
                0:       r.d = 32'(v & mask);
                1:       r.d = 32'(im);
                2:       r.d = 32'((v * 4) & mask);
                default: r.d = 32'((longint'(im) * 65536) & mask);
            endcase
        end else begin
            r.d = 32'd0;
            r.e = 1'b1;
        end
        return r;
    endfunction

    task automatic cyc(input bit v, input int s, input int m, input int im, input bit ordy);
        bit   acc;
        ent_t e;
        @(negedge clk);
        in_valid  = v;
        sel       = 3'(s);
        ext_mode  = 2'(m);
        imm       = 16'(im);
        out_ready = ordy;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        acc = v && (q.size() < 2);
        e   = ref_op(s, m, im);
        @(posedge clk);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (e.e && errc < 255) errc++;
        end
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("operand", {32'd0, operand}, {32'd0, q[0].d});
            chk("sel_err", {63'd0, sel_err}, {63'd0, q[0].e});
        end
        chk("err_count", {56'd0, err_count}, 64'(errc));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        errc  = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        sel = '0;
        ext_mode = '0;
        imm = '0;
        out_ready = 1'b0;
        src[0] = 32'h0000_00AA;
        src[1] = 32'h1234_5678;
        src[2] = 32'hDEAD_BEEF;
        src[3] = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_operand", {32'd0, operand}, 64'd0);
        chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
        chk("rst_err_count", {56'd0, err_count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic latency
        cyc(1, 0, 0, 0, 1);
        chk("t1_operand", {32'd0, operand}, 64'h0000_00AA);
        cyc(0, 0, 0, 0, 1);
        chk("t1_drained", {63'd0, out_valid}, 64'd0);

        // Immediate extension modes
        cyc(1, 5, 0, 16'h8004, 1);
        chk("ext00", {32'd0, operand}, 64'hFFFF_8004);
        cyc(1, 5, 1, 16'h8004, 1);
        chk("ext01", {32'd0, operand}, 64'h0000_8004);
        cyc(1, 5, 2, 16'h8004, 1);
        chk("ext10", {32'd0, operand}, 64'hFFFE_0010);
        cyc(1, 5, 3, 16'h8004, 1);
        chk("ext11", {32'd0, operand}, 64'h8004_0000);
        cyc(0, 0, 0, 0, 1);

        // Skid fill and drain
        cyc(1, 4, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("skid_hold", {32'd0, operand}, 64'h0000_0004);
        chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
        cyc(0, 0, 0, 0, 1);
        chk("skid_out", {32'd0, operand}, 64'h1234_5678);
        cyc(0, 0, 0, 0, 1);
        chk("skid_ready_back", {63'd0, in_ready}, 64'd1);

        // Illegal-select saturation
        for (int i = 0; i < 300; i++) cyc(1, 7, 0, 0, 1);
        chk("err_sat", {56'd0, err_count}, 64'd255);
        cyc(0, 0, 0, 0, 1);

        // Reset while output and skid are full
        cyc(1, 2, 0, 0, 0);
        cyc(1, 3, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_operand", {32'd0, operand}, 64'd0);
        chk("mrst_err_count", {56'd0, err_count}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
        q.delete();
        errc = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

        // Continuous streaming, no bubbles
        for (int i = 0; i < 24; i++) cyc(1, i % 6, i % 4, 16'h7F31 + i, 1);
        cyc(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) src[$urandom_range(0, 3)] = $urandom;
            cyc(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                bit'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
